// File: rtl/mprj_io_cfg_pkg.sv
// Shared types and constants for the MPRJ pad configuration sequencer.
package mprj_io_cfg_pkg;

  typedef enum logic [2:0] {
    SAFE,
    SHIFT,
    REN_UPD,
    SETTLE,
    OEN_UPD,
    ACTIVE
  } cfg_state_t;

  // Bit positions inside one pad's configuration field
  localparam int CFG_OE_BIT      = 0;
  localparam int CFG_PULLDIS_BIT = 1;

  // Pad control levels while in reset or SAFE: input with pull enabled
  localparam logic SAFE_OEN = 1'b1;
  localparam logic SAFE_REN = 1'b0;

endpackage

// File: rtl/mprj_io_cfg_shreg.sv
// Serial configuration chain with saturating bit counter and optional readback.
// Readback is built only when MPRJ_IO_CFG_READBACK_EN is defined.
module mprj_io_cfg_shreg #(
  parameter int SR_W  = 76,
  parameter int CNT_W = $clog2(SR_W + 1)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             shift,
  input  logic             shift_data,
  input  logic             clr_cnt,
  output logic [SR_W-1:0]  sr_nxt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             ser_out
);

  // Count one past a full chain so an over-long load is distinguishable
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SR_W + 1);

  logic [SR_W-1:0]  sr_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_comb begin
    sr_nxt  = sr_reg;
    cnt_nxt = cnt_reg;
    if (shift) begin
      sr_nxt = {shift_data, sr_reg[SR_W-1:1]};
      if (clr_cnt)
        cnt_nxt = CNT_W'(1);
      else if (cnt_reg != CNT_MAX)
        cnt_nxt = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      sr_reg  <= sr_nxt;
      cnt_reg <= cnt_nxt;
    end
  end

`ifdef MPRJ_IO_CFG_READBACK_EN
  // Captures the bit leaving the chain, so a full pass reads back first-in-first-out
  logic ser_reg;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)
      ser_reg <= 1'b0;
    else if (shift)
      ser_reg <= sr_reg[0];
  end

  assign ser_out = ser_reg;
`else
  assign ser_out = 1'b0;
`endif

endmodule

// File: rtl/mprj_io_cfg_seq.sv
// Per-pad OEN/REN sequencer: applies a serially loaded config REN first, OEN after a settle delay.
// Define MPRJ_IO_CFG_READBACK_EN to enable chain readback on ser_out.
module mprj_io_cfg_seq
  import mprj_io_cfg_pkg::*;
#(
  parameter int NUM_IO     = 38,
  parameter int SETTLE_CYC = 16,
  parameter int CFG_BITS   = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              shift_en,
  input  logic              shift_data,
  input  logic              apply,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [NUM_IO-1:0] pad_oen,
  output logic [NUM_IO-1:0] pad_ren,
  output logic              ser_out
);

  localparam int SR_W  = CFG_BITS * NUM_IO;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SR_W);
  localparam logic [SET_W-1:0] SET_START = SET_W'(SETTLE_CYC - 1);

  cfg_state_t        state_reg, state_next;
  logic [SET_W-1:0]  settle_reg, settle_next;
  logic [NUM_IO-1:0] pad_oen_reg, pad_oen_next;
  logic [NUM_IO-1:0] pad_ren_reg, pad_ren_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic              shift_ok;
  logic              clr_cnt;
  logic [SR_W-1:0]   sr_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_IO-1:0] ren_tgt;
  logic [NUM_IO-1:0] oen_tgt;

  assign shift_ok = shift_en && (state_reg inside {SAFE, SHIFT, ACTIVE});
  assign clr_cnt  = shift_en && (state_reg inside {SAFE, ACTIVE});

  mprj_io_cfg_shreg #(
    .SR_W  (SR_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clock      (clock),
    .resetb     (resetb),
    .shift      (shift_ok),
    .shift_data (shift_data),
    .clr_cnt    (clr_cnt),
    .sr_nxt     (sr_nxt),
    .cnt_nxt    (cnt_nxt),
    .ser_out    (ser_out)
  );

  // Targets come from the post-shift chain so a shift coinciding with apply is included;
  // once busy the chain is frozen, so the same view is valid for the later OEN step.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_tgt
      assign ren_tgt[gi] = sr_nxt[CFG_BITS*gi + CFG_PULLDIS_BIT];
      assign oen_tgt[gi] = ~sr_nxt[CFG_BITS*gi + CFG_OE_BIT];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    settle_next  = settle_reg;
    pad_oen_next = pad_oen_reg;
    pad_ren_next = pad_ren_reg;
    done_next    = 1'b0;
    err_next     = apply && !(state_reg == SHIFT && cnt_nxt == CNT_FULL);

    // Pad registers update on the edge that enters REN_UPD / OEN_UPD
    case (state_reg)
      SAFE: begin
        if (shift_en) state_next = SHIFT;
      end
      SHIFT: begin
        if (apply && cnt_nxt == CNT_FULL) begin
          pad_ren_next = ren_tgt;
          state_next   = REN_UPD;
        end
      end
      REN_UPD: begin
        settle_next = SET_START;
        state_next  = SETTLE;
      end
      SETTLE: begin
        if (settle_reg == '0) begin
          pad_oen_next = oen_tgt;
          state_next   = OEN_UPD;
        end else begin
          settle_next = settle_reg - 1'b1;
        end
      end
      OEN_UPD: begin
        done_next  = 1'b1;
        state_next = ACTIVE;
      end
      ACTIVE: begin
        if (shift_en) state_next = SHIFT;
      end
      default: state_next = SAFE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg   <= SAFE;
      settle_reg  <= '0;
      pad_oen_reg <= {NUM_IO{SAFE_OEN}};
      pad_ren_reg <= {NUM_IO{SAFE_REN}};
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      settle_reg  <= settle_next;
      pad_oen_reg <= pad_oen_next;
      pad_ren_reg <= pad_ren_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign busy     = state_reg inside {REN_UPD, SETTLE, OEN_UPD};
  assign cfg_done = done_reg;
  assign cfg_err  = err_reg;
  assign pad_oen  = pad_oen_reg;
  assign pad_ren  = pad_ren_reg;

endmodule
